regfile_2w2r: RTL and testbench

REGFILE_2W2R -- requirements
Module: regfile_2w2r

---
 rtl/regfile_2w2r.sv | 127 ++++++++++++
 tb/tb_regfile_2w2r.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_2w2r.sv
// Two-write / two-read register file with a self-zeroing clear sweep after reset or clr.
// Optional same-cycle write-to-read forwarding is compiled in with `define REGFILE_BYPASS_EN.
//
// state | meaning
// CLEAR | sweeping zeros into every register; ports ignored; busy=1
// READY | normal read/write operation
module regfile_2w2r #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              w0_en,
    input  logic [ADDR_W-1:0] w0_addr,
    input  logic [DATA_W-1:0] w0_data,
    input  logic              w1_en,
    input  logic [ADDR_W-1:0] w1_addr,
    input  logic [DATA_W-1:0] w1_data,
    input  logic              r0_en,
    input  logic [ADDR_W-1:0] r0_addr,
    input  logic              r1_en,
    input  logic [ADDR_W-1:0] r1_addr,
    output logic [DATA_W-1:0] r0_data,
    output logic              r0_valid,
    output logic [DATA_W-1:0] r1_data,
    output logic              r1_valid,
    output logic              busy
);

    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] sweep_cnt;
    logic              sweep_done;
    logic              ready;
    logic              w0_ok;
    logic              w1_ok;
    logic [DATA_W-1:0] r0_rd;
    logic [DATA_W-1:0] r1_rd;
    logic [DATA_W-1:0] mem [DEPTH];

    assign sweep_done = (sweep_cnt == ADDR_W'(DEPTH - 1));
    assign ready      = (state == READY);
    assign busy       = (state == CLEAR);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= CLEAR;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            CLEAR:   if (sweep_done) state_nxt = READY;
            READY:   if (clr)        state_nxt = CLEAR;
            default:                 state_nxt = CLEAR;
        endcase
    end

    // Counter parks at zero in READY so a later clr sweep starts at address 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sweep_cnt <= '0;
        end else if (state == CLEAR) begin
            sweep_cnt <= sweep_cnt + 1'b1;
        end else begin
            sweep_cnt <= '0;
        end
    end

    assign w0_ok = ready && w0_en && !((ZERO_REG != 0) && (w0_addr == '0));
    assign w1_ok = ready && w1_en && !((ZERO_REG != 0) && (w1_addr == '0));

    // Storage has no reset; port 1 is assigned last so it wins a collision.
    always_ff @(posedge clk) begin
        if (state == CLEAR) begin
            mem[sweep_cnt] <= '0;
        end else begin
            if (w0_ok) mem[w0_addr] <= w0_data;
            if (w1_ok) mem[w1_addr] <= w1_data;
        end
    end

    always_comb begin
        r0_rd = mem[r0_addr];
`ifdef REGFILE_BYPASS_EN
        if (w0_ok && (w0_addr == r0_addr)) r0_rd = w0_data;
        if (w1_ok && (w1_addr == r0_addr)) r0_rd = w1_data;
`endif
        if ((ZERO_REG != 0) && (r0_addr == '0)) r0_rd = '0;
    end

    always_comb begin
        r1_rd = mem[r1_addr];
`ifdef REGFILE_BYPASS_EN
        if (w0_ok && (w0_addr == r1_addr)) r1_rd = w0_data;
        if (w1_ok && (w1_addr == r1_addr)) r1_rd = w1_data;
`endif
        if ((ZERO_REG != 0) && (r1_addr == '0)) r1_rd = '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r0_data  <= '0;
            r0_valid <= 1'b0;
            r1_data  <= '0;
            r1_valid <= 1'b0;
        end else begin
            r0_valid <= ready && r0_en;
            r1_valid <= ready && r1_en;
            if (ready && r0_en) r0_data <= r0_rd;
            if (ready && r1_en) r1_data <= r1_rd;
        end
    end

endmodule

// File: tb/tb_regfile_2w2r.sv
// Directed self-checking bench for regfile_2w2r; expectation for the forwarding case
// follows whether REGFILE_BYPASS_EN is defined for the build.
module tb_regfile_2w2r;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clr = 1'b0;
    logic        w0_en = 1'b0, w1_en = 1'b0, r0_en = 1'b0, r1_en = 1'b0;
    logic [4:0]  w0_addr = '0, w1_addr = '0, r0_addr = '0, r1_addr = '0;
    logic [31:0] w0_data = '0, w1_data = '0;
    logic [31:0] r0_data, r1_data;
    logic        r0_valid, r1_valid, busy;

    int checks = 0;
    int failures = 0;

    regfile_2w2r #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1)) dut (
        .clk(clk), .rst(rst), .clr(clr),
        .w0_en(w0_en), .w0_addr(w0_addr), .w0_data(w0_data),
        .w1_en(w1_en), .w1_addr(w1_addr), .w1_data(w1_data),
        .r0_en(r0_en), .r0_addr(r0_addr),
        .r1_en(r1_en), .r1_addr(r1_addr),
        .r0_data(r0_data), .r0_valid(r0_valid),
        .r1_data(r1_data), .r1_valid(r1_valid),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        clr = 0; w0_en = 0; w1_en = 0; r0_en = 0; r1_en = 0;
    endtask

    // Ticks until busy drops (bounded); returns number of busy samples seen.
    task automatic count_busy(output int n);
        n = 0;
        while (busy && n < 100) begin
            tick();
            n++;
        end
    endtask

    task automatic test_reset();
        int n;
        // Fill the array with non-zero data so the sweep is observable.
        rst = 1; tick(); rst = 0;
        count_busy(n);
        for (int i = 0; i < 32; i++) begin
            w0_en = 1; w0_addr = 5'(i); w0_data = 32'h100 + i;
            tick();
        end
        idle();
        rst = 1; #1;
        checks++;
        if (busy !== 1'b1 || r0_valid !== 1'b0 || r0_data !== 32'h0 || r1_data !== 32'h0) begin
            failures++;
            $display("FAIL reset_outputs busy=%b r0_valid=%b r0_data=%h r1_data=%h want 1 0 0 0",
                     busy, r0_valid, r0_data, r1_data);
        end
        tick(); rst = 0;
        count_busy(n);
        checks++;
        if (n != 32) begin
            failures++;
            $display("FAIL reset_busy_len got=%0d want=32", n);
        end
        for (int i = 0; i < 32; i++) begin
            r0_en = 1; r0_addr = 5'(i); r1_en = 1; r1_addr = 5'(31 - i);
            tick();
            checks++;
            if (r0_data !== 32'h0 || r0_valid !== 1'b1 || r1_data !== 32'h0 || r1_valid !== 1'b1) begin
                failures++;
                $display("FAIL sweep_zero addr=%0d r0=%h/%b r1=%h/%b want 0/1", i, r0_data, r0_valid,
                         r1_data, r1_valid);
            end
        end
        idle(); tick();
    endtask

    task automatic test_bypass();
        logic [31:0] exp;
`ifdef REGFILE_BYPASS_EN
        exp = 32'h3;
`else
        exp = 32'h0;
`endif
        w1_en = 1; w1_addr = 7; w1_data = 32'h3;
        r1_en = 1; r1_addr = 7;
        tick(); idle();
        checks++;
        if (r1_data !== exp || r1_valid !== 1'b1) begin
            failures++;
            $display("FAIL bypass r1_data=%h valid=%b want %h 1", r1_data, r1_valid, exp);
        end
        r1_en = 1; r1_addr = 7; tick(); idle();
        checks++;
        if (r1_data !== 32'h3) begin
            failures++;
            $display("FAIL bypass_stored r1_data=%h want 3", r1_data);
        end
    endtask

    task automatic test_write_read();
        w0_en = 1; w0_addr = 4; w0_data = 32'h12;
        tick(); idle();
        r0_en = 1; r0_addr = 4;
        #1;
        checks++;
        if (r0_valid !== 1'b0) begin
            failures++;
            $display("FAIL read_latency valid=%b before edge want 0", r0_valid);
        end
        tick(); idle();
        checks++;
        if (r0_data !== 32'h12 || r0_valid !== 1'b1) begin
            failures++;
            $display("FAIL write_read r0_data=%h valid=%b want 12 1", r0_data, r0_valid);
        end
        tick();
        checks++;
        if (r0_data !== 32'h12 || r0_valid !== 1'b0) begin
            failures++;
            $display("FAIL read_hold r0_data=%h valid=%b want 12 0", r0_data, r0_valid);
        end
    endtask

    task automatic test_collision();
        w0_en = 1; w0_addr = 20; w0_data = 32'hAA;
        w1_en = 1; w1_addr = 20; w1_data = 32'h55;
        tick(); idle();
        r0_en = 1; r0_addr = 20;
        tick(); idle();
        checks++;
        if (r0_data !== 32'h55) begin
            failures++;
            $display("FAIL collision r0_data=%h want 55", r0_data);
        end
    endtask

    task automatic test_zero_reg();
        w0_en = 1; w0_addr = 0; w0_data = 32'hFFFF_FFFF;
        w1_en = 1; w1_addr = 0; w1_data = 32'hFFFF_FFFF;
        tick(); idle();
        r0_en = 1; r0_addr = 0; r1_en = 1; r1_addr = 0;
        tick(); idle();
        checks++;
        if (r0_data !== 32'h0 || r1_data !== 32'h0) begin
            failures++;
            $display("FAIL zero_reg r0=%h r1=%h want 0 0", r0_data, r1_data);
        end
    endtask

    task automatic test_dual_read();
        w0_en = 1; w0_addr = 11; w0_data = 32'hDEAD_BEEF;
        w1_en = 1; w1_addr = 12; w1_data = 32'hCAFE_F00D;
        tick(); idle();
        r0_en = 1; r0_addr = 11; r1_en = 1; r1_addr = 11;
        tick();
        checks++;
        if (r0_data !== 32'hDEAD_BEEF || r1_data !== 32'hDEAD_BEEF) begin
            failures++;
            $display("FAIL dual_same r0=%h r1=%h want deadbeef deadbeef", r0_data, r1_data);
        end
        r0_addr = 12; r1_addr = 20;
        tick(); idle();
        checks++;
        if (r0_data !== 32'hCAFE_F00D || r1_data !== 32'h55) begin
            failures++;
            $display("FAIL dual_diff r0=%h r1=%h want cafef00d 55", r0_data, r1_data);
        end
    endtask

    task automatic test_clr();
        int n;
        // Read issued with clr must still complete; second clr mid-sweep must not restart.
        w0_en = 1; w0_addr = 9; w0_data = 32'h99;
        r0_en = 1; r0_addr = 4; clr = 1;
        tick(); idle();
        checks++;
        if (r0_valid !== 1'b1 || r0_data !== 32'h12 || busy !== 1'b1) begin
            failures++;
            $display("FAIL clr_same_cycle valid=%b r0=%h busy=%b want 1 12 1", r0_valid, r0_data, busy);
        end
        n = 0;
        while (busy && n < 100) begin
            clr   = (n == 5);
            r1_en = 1; r1_addr = 12;
            w1_en = 1; w1_addr = 12; w1_data = 32'h777;
            tick();
            n++;
            if (r1_valid !== 1'b0) begin
                checks++;
                failures++;
                $display("FAIL clear_read_ignored cycle=%0d r1_valid=%b want 0", n, r1_valid);
            end
        end
        idle();
        checks++;
        if (n != 32 || r1_data !== 32'h55) begin
            failures++;
            $display("FAIL clr_busy_len got=%0d r1_data=%h want 32 55", n, r1_data);
        end
        r0_en = 1; r0_addr = 9; r1_en = 1; r1_addr = 12;
        tick(); idle();
        checks++;
        if (r0_data !== 32'h0 || r1_data !== 32'h0) begin
            failures++;
            $display("FAIL clr_zeroed r0=%h r1=%h want 0 0", r0_data, r1_data);
        end
    endtask

    task automatic test_mid_sweep_reset();
        int n;
        w0_en = 1; w0_addr = 31; w0_data = 32'h31;
        tick(); idle();
        rst = 1; tick(); rst = 0;
        for (int i = 0; i < 10; i++) tick();
        rst = 1; #1;
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL mid_rst_busy busy=%b want 1", busy);
        end
        tick(); rst = 0;
        count_busy(n);
        checks++;
        if (n != 32) begin
            failures++;
            $display("FAIL mid_rst_busy_len got=%0d want=32", n);
        end
        r0_en = 1; r0_addr = 31;
        tick(); idle();
        checks++;
        if (r0_data !== 32'h0 || r0_valid !== 1'b1) begin
            failures++;
            $display("FAIL mid_rst_zeroed r0=%h valid=%b want 0 1", r0_data, r0_valid);
        end
    endtask

    initial begin
        #1;
        test_reset();
        test_bypass();
        test_write_read();
        test_collision();
        test_zero_reg();
        test_dual_read();
        test_clr();
        test_mid_sweep_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
